// File: rtl/mc_control.sv
// mc_control: multi-cycle sequencing controller for the 32-bit MIPS datapath.
// It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving
// the datapath enables and mux selects in each state. It also counts retired
// instructions.
//
// Optional feature macro: MC_MEM_WAIT_EN
//   defined   - MEM stalls while mem_ready is low.
//   undefined - mem_ready is ignored and MEM always lasts one cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   opcode     in   instruction[31:26] from the instruction register
//   funct      in   instruction[5:0]
//   eq_zero    in   ALU zero flag, selects the beq target
//   mem_ready  in   data_ram access complete (MC_MEM_WAIT_EN only)
//   ir_write   out  load the IR from inst_ram
//   pc_write   out  load the PC from the pc_src mux
//   pc_src     out  0 pc+4, 1 branch target, 2 jump target
//   reg_write  out  regfile write enable
//   reg_dest   out  1 rd, 0 rt
//   mem_to_reg out  1 memory, 0 ALU
//   alu_src    out  1 sign-extended immediate, 0 rt
//   alu_op     out  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
//   mem_read   out  data_ram read strobe
//   mem_write  out  data_ram write strobe
//   trap       out  illegal instruction decoded
//   state      out  current state, for debug
//   retired    out  retired-instruction count, wraps at 2^32
module mc_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        eq_zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        reg_dest,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd7
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    state_e      state_q, state_d;
    logic [31:0] retired_q;

    // Instruction decode
    logic       is_r, is_lw, is_sw, is_addi, is_beq, is_j, legal;
    logic [2:0] r_alu_op;
    logic       r_funct_ok;

    always_comb begin
        r_funct_ok = 1'b1;
        r_alu_op   = AluAdd;
        unique case (funct)
            6'b100000: r_alu_op = AluAdd;
            6'b100010: r_alu_op = AluSub;
            6'b100100: r_alu_op = AluAnd;
            6'b100101: r_alu_op = AluOr;
            6'b101010: r_alu_op = AluSlt;
            default:   r_funct_ok = 1'b0;
        endcase
    end

    assign is_r    = (opcode == 6'b000000) && r_funct_ok;
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_addi = (opcode == 6'b001000);
    assign is_beq  = (opcode == 6'b000100);
    assign is_j    = (opcode == 6'b000010);
    assign legal   = is_r | is_lw | is_sw | is_addi | is_beq | is_j;

    logic mem_done;
`ifdef MC_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = AluAdd;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        trap       = 1'b0;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch: begin
                ir_write = 1'b1;
                state_d  = StDecode;
            end
            StDecode: state_d = legal ? StExec : StTrap;
            StExec: begin
                state_d = StFetch;
                if (is_r) begin
                    alu_op  = r_alu_op;
                    state_d = StWb;
                end else if (is_lw || is_sw) begin
                    alu_src = 1'b1;
                    state_d = StMem;
                end else if (is_addi) begin
                    alu_src = 1'b1;
                    state_d = StWb;
                end else if (is_beq) begin
                    alu_op   = AluSub;
                    pc_write = 1'b1;
                    pc_src   = eq_zero ? 2'd1 : 2'd0;
                end else if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
            end
            StMem: begin
                // ADD with the immediate is held so the address stays stable.
                alu_src = 1'b1;
                if (is_lw) begin
                    mem_read = 1'b1;
                    if (mem_done) state_d = StWb;
                end else if (is_sw) begin
                    mem_write = 1'b1;
                    pc_write  = mem_done;
                    if (mem_done) state_d = StFetch;
                end else begin
                    state_d = StFetch;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StFetch;
                if (is_r) begin
                    reg_dest = 1'b1;
                end else if (is_lw) begin
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                end else if (is_addi) begin
                    alu_src = 1'b1;
                end
            end
            StTrap:   trap = 1'b1;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // pc_write fires exactly once per retired instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= 32'd0;
        end else if (pc_write) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'b000000;
    logic [5:0]  funct = 6'b100000;
    logic        eq_zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        ir_write, pc_write, reg_write, reg_dest, mem_to_reg, alu_src;
    logic        mem_read, mem_write, trap;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op, state;
    logic [31:0] retired;

    mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .eq_zero    (eq_zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dest   (reg_dest),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .trap       (trap),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Control vector bit positions
    localparam int BIr = 13, BPw = 12, BPs = 10, BRw = 9, BRd = 8, BM2r = 7;
    localparam int BAs = 6, BAop = 3, BMr = 2, BMw = 1, BTr = 0;

`ifdef MC_MEM_WAIT_EN
    localparam bit WaitEn = 1'b1;
`else
    localparam bit WaitEn = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] ctl;
        logic [31:0] ret;
        logic        mr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_ret = 32'd0;
    int          trap_cycles = 20;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    logic [13:0] dut_ctl;
    assign dut_ctl = {ir_write, pc_write, pc_src, reg_write, reg_dest, mem_to_reg, alu_src,
                      alu_op, mem_read, mem_write, trap};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, got, want);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [13:0] c, input logic mr);
        exp_t e;
        e.st  = st;
        e.ctl = c;
        e.ret = model_ret;
        e.mr  = mr;
        q.push_back(e);
        if (c[BPw]) model_ret = model_ret + 32'd1;
    endtask

    // Expected per-cycle behaviour of one instruction, FETCH up to the next FETCH.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic eqz,
                              input int waits, input bit cut_before_mem);
        int          kind;  // 0 R, 1 lw, 2 sw, 3 addi, 4 beq, 5 j, 6 illegal
        logic [2:0]  rop;
        logic [13:0] c;
        int          nw;
        rop  = 3'd0;
        kind = 6;
        case (op)
            6'b000000: begin
                kind = 0;
                case (fn)
                    6'b100000: rop = 3'b000;
                    6'b100010: rop = 3'b001;
                    6'b100100: rop = 3'b010;
                    6'b100101: rop = 3'b011;
                    6'b101010: rop = 3'b100;
                    default:   kind = 6;
                endcase
            end
            6'b100011: kind = 1;
            6'b101011: kind = 2;
            6'b001000: kind = 3;
            6'b000100: kind = 4;
            6'b000010: kind = 5;
            default:   kind = 6;
        endcase
        c = '0; c[BIr] = 1'b1;
        push(3'd1, c, 1'b1);
        push(3'd2, 14'd0, 1'b1);
        if (kind == 6) begin
            c = '0; c[BTr] = 1'b1;
            for (int i = 0; i < trap_cycles; i++) push(3'd7, c, 1'b1);
            return;
        end
        c = '0;
        case (kind)
            0: c[BAop+:3] = rop;
            1, 2, 3: c[BAs] = 1'b1;
            4: begin c[BAop+:3] = 3'b001; c[BPw] = 1'b1; c[BPs+:2] = eqz ? 2'd1 : 2'd0; end
            default: begin c[BPw] = 1'b1; c[BPs+:2] = 2'd2; end
        endcase
        push(3'd3, c, 1'b1);
        if (cut_before_mem) return;
        if (kind == 1 || kind == 2) begin
            nw = WaitEn ? waits : 0;
            c = '0; c[BAs] = 1'b1;
            if (kind == 1) c[BMr] = 1'b1; else c[BMw] = 1'b1;
            for (int i = 0; i < nw; i++) push(3'd4, c, 1'b0);
            if (kind == 2) c[BPw] = 1'b1;
            push(3'd4, c, 1'b1);
        end
        if (kind == 0 || kind == 1 || kind == 3) begin
            c = '0; c[BRw] = 1'b1; c[BPw] = 1'b1;
            if (kind == 0) c[BRd] = 1'b1;
            if (kind == 1) begin c[BM2r] = 1'b1; c[BAs] = 1'b1; end
            if (kind == 3) c[BAs] = 1'b1;
            push(3'd5, c, 1'b1);
        end
    endtask

    // Returns at posedge+1 once every queued expectation has been checked.
    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic eqz,
                       input int waits);
        opcode  = op;
        funct   = fn;
        eq_zero = eqz;
        push_instr(op, fn, eqz, waits, 1'b0);
        drain();
    endtask

    // Asserts reset now, checks the immediate effect, releases after one edge.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_ctl", dut_ctl, 0);
        chk("rst_retired", retired, 0);
        model_ret = 32'd0;
        @(posedge clk);
        #1;
        chk("rst_hold_state", state, 0);
        reset = 1'b1;
        push(3'd0, 14'd0, 1'b1);
    endtask

    // mem_ready for the current cycle comes from the expectation being checked.
    always @(posedge clk) begin
        #2;
        mem_ready = (q.size() != 0) ? q[0].mr : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("state", {29'd0, state}, {29'd0, e.st});
            chk("ctl", {18'd0, dut_ctl}, {18'd0, e.ctl});
            chk("retired", retired, e.ret);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        chk("init_state", state, 0);
        chk("init_ctl", dut_ctl, 0);
        chk("init_retired", retired, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        push(3'd0, 14'd0, 1'b1);
        opcode = 6'b000000;
        funct  = 6'b100000;
        push_instr(6'b000000, 6'b100000, 1'b0, 0, 1'b0);
        chk("len_r", q.size(), 5);
        drain();
        chk("add_retired", retired, 1);

        run(6'b000000, 6'b100010, 1'b0, 0);
        run(6'b000000, 6'b100100, 1'b0, 0);
        run(6'b000000, 6'b100101, 1'b0, 0);
        run(6'b000000, 6'b101010, 1'b0, 0);
        run(6'b001000, 6'b111111, 1'b0, 0);

        opcode = 6'b100011;
        funct  = 6'b000000;
        push_instr(6'b100011, 6'b000000, 1'b0, 3, 1'b0);
        chk("len_lw", q.size(), WaitEn ? 8 : 5);
        drain();

        opcode = 6'b101011;
        push_instr(6'b101011, 6'b000000, 1'b0, 0, 1'b0);
        chk("len_sw", q.size(), 4);
        drain();

        opcode  = 6'b000100;
        eq_zero = 1'b1;
        push_instr(6'b000100, 6'b000000, 1'b1, 0, 1'b0);
        chk("len_beq", q.size(), 3);
        drain();
        run(6'b000100, 6'b000000, 1'b0, 0);
        run(6'b000010, 6'b000000, 1'b0, 0);
        chk("retired_11", retired, 11);

        // Illegal opcode: parked in TRAP, count frozen
        trap_cycles = 20;
        run(6'b111111, 6'b000000, 1'b0, 0);
        chk("trap_state", state, 7);
        chk("trap_flag", trap, 1);
        chk("trap_retired", retired, 11);
        pulse_reset();

        // Illegal R-type funct
        trap_cycles = 5;
        run(6'b000000, 6'b000001, 1'b0, 0);
        chk("trap2_state", state, 7);
        pulse_reset();

        run(6'b000000, 6'b100000, 1'b0, 0);
        // sw abandoned by reset during MEM
        opcode = 6'b101011;
        push_instr(6'b101011, 6'b000000, 1'b0, 0, 1'b1);
        drain();
        chk("sw_mem_state", state, 4);
        chk("sw_mem_write", mem_write, 1);
        chk("sw_retired_pre", retired, 1);
        pulse_reset();
        run(6'b000000, 6'b100000, 1'b0, 0);
        chk("resume_retired", retired, 1);

        // Counter wrap: preload then retire a jump
        opcode = 6'b000010;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        model_ret = 32'hFFFF_FFFF;
        push_instr(6'b000010, 6'b000000, 1'b0, 0, 1'b0);
        drain();
        chk("wrap_retired", retired, 0);
        run(6'b001000, 6'b000000, 1'b0, 0);
        chk("post_wrap_retired", retired, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
